// File: rtl/vote_tally_fsm_if.sv
// rtl/vote_tally_fsm_if.sv - voting round handshake and result bus (veto port with VOTE_VETO_EN)
interface vote_tally_fsm_if #(
   parameter int N_VOTERS = 7,
   parameter int CNT_W    = $clog2(N_VOTERS + 1)
);
   logic                start;
   logic [N_VOTERS-1:0] vote;
`ifdef VOTE_VETO_EN
   logic                veto;
`endif
   logic                busy;
   logic                done;
   logic                pass;
   logic [CNT_W-1:0]    tally;

`ifdef VOTE_VETO_EN
   modport master (output start, vote, veto, input busy, done, pass, tally);
   modport slave  (input start, vote, veto, output busy, done, pass, tally);
`else
   modport master (output start, vote, input busy, done, pass, tally);
   modport slave  (input start, vote, output busy, done, pass, tally);
`endif
endinterface

// File: rtl/vote_tally_fsm.sv
// rtl/vote_tally_fsm.sv - timed-window sticky majority voter with registered tally/pass
// Optional veto input enabled by defining VOTE_VETO_EN.
module vote_tally_fsm #(
   parameter int N_VOTERS   = 7,
   parameter int THRESHOLD  = 4,
   parameter int WINDOW_CYC = 16
) (
   input  logic            clk,
   input  logic            rst,
   vote_tally_fsm_if.slave bus
);
   localparam int CNT_W = $clog2(N_VOTERS + 1);
   localparam int WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYC - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DECIDE  = 2'd2;

   logic [1:0]          state;
   logic [N_VOTERS-1:0] latch;
   logic [WIN_W-1:0]    win_cnt;
   logic                done_r;
   logic                pass_r;
   logic [CNT_W-1:0]    tally_r;
   logic [CNT_W-1:0]    pop;
   logic                pass_c;
   logic                veto_l;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_VOTERS; i++) begin
         pop = pop + CNT_W'(latch[i]);
      end
   end

   // Compare in 32 bits so THRESHOLD values beyond the tally range still behave.
   always_comb begin
      pass_c = (32'(pop) >= 32'(THRESHOLD)) && !veto_l;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         latch   <= '0;
         win_cnt <= '0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         tally_r <= '0;
         veto_l  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  latch   <= '0;
                  veto_l  <= 1'b0;
                  win_cnt <= WIN_LOAD;
                  state   <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               latch <= latch | bus.vote;
`ifdef VOTE_VETO_EN
               veto_l <= veto_l | bus.veto;
`endif
               if (win_cnt == '0 || &(latch | bus.vote)) begin
                  state <= S_DECIDE;
               end else begin
                  win_cnt <= win_cnt - 1'b1;
               end
            end
            S_DECIDE: begin
               tally_r <= pop;
               pass_r  <= pass_c;
               done_r  <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = (state == S_COLLECT) || (state == S_DECIDE);
   assign bus.done  = done_r;
   assign bus.pass  = pass_r;
   assign bus.tally = tally_r;
endmodule

// File: tb/tb_vote_tally_fsm.sv
// tb/tb_vote_tally_fsm.sv - vector table, hand sequences and random rounds vs a round-level model
module tb_vote_tally_fsm;
   localparam int NV  = 7;
   localparam int THR = 4;
   localparam int WIN = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vote_tally_fsm_if #(.N_VOTERS(NV)) bus ();

   vote_tally_fsm #(.N_VOTERS(NV), .THRESHOLD(THR), .WINDOW_CYC(WIN)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      string    name;
      logic [6:0] start_vote;
      logic [6:0] hold;
      logic [6:0] p1; int k1;
      logic [6:0] p2; int k2;
      logic [6:0] p3; int k3;
      int       start_k;
      int       veto_k;
      logic [6:0] post;
      bit       use_rand;
      int       lat;
      int       tally;
      bit       pass;
   } vec_t;

   int passed = 0;
   int total  = 0;
   logic [6:0] rv [0:40];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [6:0] vote_for(input vec_t v, input int k);
      logic [6:0] r;
      if (k >= v.lat - 1) return v.post;
      if (v.use_rand) return rv[k];
      r = v.hold;
      if (k == v.k1) r = r | v.p1;
      if (k == v.k2) r = r | v.p2;
      if (k == v.k3) r = r | v.p3;
      return r;
   endfunction

   // Caller is 1 time unit past a rising edge; that cycle becomes the start cycle.
   task automatic run_round(input vec_t v);
      bus.start = 1'b1;
      bus.vote  = v.start_vote;
`ifdef VOTE_VETO_EN
      bus.veto  = 1'b0;
`endif
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         bus.start = (k == v.start_k);
         bus.vote  = vote_for(v, k);
`ifdef VOTE_VETO_EN
         bus.veto  = (k == v.veto_k);
`endif
         check({v.name, ".busy"}, int'(bus.busy), int'(k < v.lat));
         check({v.name, ".done"}, int'(bus.done), int'(k == v.lat));
         if (k == v.lat) begin
            check({v.name, ".tally"}, int'(bus.tally), v.tally);
            check({v.name, ".pass"},  int'(bus.pass),  int'(v.pass));
            break;
         end
      end
   endtask

   function automatic vec_t mk(input string n, input logic [6:0] hold, input int lat,
                               input int tally, input bit pass);
      vec_t v;
      v.name = n; v.start_vote = '0; v.hold = hold;
      v.p1 = '0; v.k1 = 0; v.p2 = '0; v.k2 = 0; v.p3 = '0; v.k3 = 0;
      v.start_k = 0; v.veto_k = 0; v.post = '0; v.use_rand = 1'b0;
      v.lat = lat; v.tally = tally; v.pass = pass;
      return v;
   endfunction

   vec_t tbl [$];

   initial begin
      vec_t v;
      logic [6:0] acc;
      int close;

      // Round table: expected latency counts from the start cycle to the done cycle.
      v = mk("hold4", 7'h0F, 18, 4, 1'b1); tbl.push_back(v);
      v = mk("pulses", 7'h00, 18, 3, 1'b0);
      v.p1 = 7'h01; v.k1 = 2; v.p2 = 7'h08; v.k2 = 7; v.p3 = 7'h20; v.k3 = 16; tbl.push_back(v);
      v = mk("early1", 7'h00, 3, 7, 1'b1); v.p1 = 7'h7F; v.k1 = 1; tbl.push_back(v);
      v = mk("ignored", 7'h00, 18, 0, 1'b0);
      v.start_vote = 7'h7F; v.post = 7'h7F; v.start_k = 5; tbl.push_back(v);
      v = mk("union", 7'h00, 11, 7, 1'b1);
      v.p1 = 7'h0F; v.k1 = 4; v.p2 = 7'h70; v.k2 = 9; tbl.push_back(v);
      v = mk("last", 7'h00, 18, 7, 1'b1); v.p1 = 7'h7F; v.k1 = 16; tbl.push_back(v);
      v = mk("thr_m1", 7'h07, 18, 3, 1'b0); tbl.push_back(v);
      v = mk("six", 7'h3F, 18, 6, 1'b1); tbl.push_back(v);

      bus.start = 1'b0; bus.vote = '0;
`ifdef VOTE_VETO_EN
      bus.veto = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy",  int'(bus.busy),  0);
      check("rst.done",  int'(bus.done),  0);
      check("rst.pass",  int'(bus.pass),  0);
      check("rst.tally", int'(bus.tally), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back: each round starts in the previous round's done cycle.
      foreach (tbl[i]) run_round(tbl[i]);

      // Reset mid-collect aborts without a done pulse.
      bus.start = 1'b1; bus.vote = 7'h0F;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         check("abort.busy", int'(bus.busy), 1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort.busy0",  int'(bus.busy),  0);
      check("abort.tally0", int'(bus.tally), 0);
      check("abort.pass0",  int'(bus.pass),  0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         check("abort.nodone", int'(bus.done), 0);
         check("abort.idle",   int'(bus.busy), 0);
      end
      run_round(tbl[0]);

      // Random rounds against a model working on whole-round vote histories.
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k <= 40; k++) begin
            rv[k] = 7'($urandom) & 7'($urandom);
            if ($urandom_range(3) != 0) rv[k] = rv[k] & 7'($urandom);
         end
         acc = '0;
         close = WIN;
         for (int k = 1; k <= WIN; k++) begin
            acc = acc | rv[k];
            if (acc == 7'h7F) begin close = k; break; end
         end
         v = mk("rand", 7'h00, close + 2, $countones(acc), $countones(acc) >= THR);
         v.use_rand = 1'b1;
         v.start_vote = 7'($urandom);
         v.post = 7'($urandom);
         v.start_k = int'($urandom_range(1, 20));
         run_round(v);
      end

`ifdef VOTE_VETO_EN
      v = mk("veto", 7'h3F, 18, 6, 1'b0); v.veto_k = 4; run_round(v);
      v = mk("noveto", 7'h3F, 18, 6, 1'b1); run_round(v);
      v = mk("veto_full", 7'h00, 3, 7, 1'b0); v.p1 = 7'h7F; v.k1 = 1; v.veto_k = 1; run_round(v);
`endif

      @(posedge clk); #1;
      check("final.nodone", int'(bus.done), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
